// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the DM_Core access controller.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Little-endian byte-lane write mask; reserved size behaves as word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] alo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << alo;
      SZ_HALF: m = 4'b0011 << {alo[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] alo);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && alo[0]) ||
           ((size == SZ_WORD) && (alo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Combinational lane select and sign/zero extension of a BRAM read word.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] i_dout,
  input  logic [1:0]  i_alo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_dout[{i_alo, 3'b000} +: 8];
  assign w_half = i_alo[1] ? i_dout[31:16] : i_dout[15:0];

  always_comb begin
    o_data = i_dout;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_dout;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// DM_Core load/store initiator: response 3 edges after accept; req_ready only in IDLE, response held until resp_ready.
// Optional DM_ALIGN_CHECK_EN: misaligned/reserved requests skip the BRAM and respond with resp_err.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dm_en,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout
);

  logic [1:0]        r_state;
  logic              r_cap_phase;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_alo;
  logic [DATA_W-1:0] r_dout;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_dm_en;
  logic [3:0]        r_dm_we;
  logic [ADDR_W-1:0] r_dm_addr;
  logic [DATA_W-1:0] r_dm_din;
  logic [DATA_W-1:0] w_ext;

  dm_load_ext u_load_ext (
    .i_dout   (r_dout),
    .i_alo    (r_alo),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

`ifdef DM_ALIGN_CHECK_EN
  logic r_resp_err;
  assign resp_err = r_resp_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_err <= 1'b0;
    end else if (r_state == ST_IDLE && req_valid) begin
      r_resp_err <= misaligned(req_size, req_addr[1:0]);
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cap_phase  <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_alo        <= 2'b00;
      r_dout       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_dm_en      <= 1'b0;
      r_dm_we      <= 4'b0000;
      r_dm_addr    <= '0;
      r_dm_din     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_alo       <= req_addr[1:0];
            r_req_ready <= 1'b0;
`ifdef DM_ALIGN_CHECK_EN
            if (misaligned(req_size, req_addr[1:0])) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
            end else
`endif
            begin
              r_state   <= ST_ISSUE;
              r_dm_en   <= 1'b1;
              r_dm_we   <= req_we ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
              r_dm_addr <= req_addr[ADDR_W+1:2];
              r_dm_din  <= store_rep(req_size, req_wdata);
            end
          end
        end
        ST_ISSUE: begin
          r_dm_en     <= 1'b0;
          r_dm_we     <= 4'b0000;
          r_cap_phase <= 1'b0;
          r_state     <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Raw BRAM word is retimed first so the lane mux never sits on douta's clock-to-out path.
          if (!r_cap_phase) begin
            r_dout      <= dm_dout;
            r_cap_phase <= 1'b1;
          end else begin
            r_resp_rdata <= r_we ? '0 : w_ext;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        default: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign dm_en      = r_dm_en;
  assign dm_we      = r_dm_we;
  assign dm_addr    = r_dm_addr;
  assign dm_din     = r_dm_din;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural single-port BRAM (1-cycle read latency).
module tb_dm_access_ctrl;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_en;
  logic [3:0]  dm_we;
  logic [10:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout = '0;
  logic [31:0] mem [0:2047] = '{default: 32'h0};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [10:0] last_addr;
  int          en_cnt;

  dm_access_ctrl #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_en) begin
      for (int i = 0; i < 4; i++)
        if (dm_we[i]) mem[dm_addr][8*i +: 8] <= dm_din[8*i +: 8];
      dm_dout <= mem[dm_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [12:0] addr, input logic [31:0] wd, input int hold,
                        input logic [3:0] exp_we, input logic [31:0] exp_din,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n, lat, ecnt, wcnt;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_rdy_lo"}, 32'(req_ready), 32'd0);
    check({tag, "_we"}, 32'(dm_we), 32'(exp_we));
    if (we) check({tag, "_din"}, dm_din, exp_din);
    if (!exp_err) check({tag, "_addr"}, 32'(dm_addr), 32'(addr[12:2]));
    last_addr = dm_addr;
    ecnt = dm_en ? 1 : 0;
    wcnt = 0;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (dm_en) ecnt++;
      if (dm_we != 4'b0000) wcnt++;
    end
    check({tag, "_lat"}, 32'(lat), exp_err ? 32'd0 : 32'd3);
    check({tag, "_en_cnt"}, 32'(ecnt), exp_err ? 32'd0 : 32'd1);
    check({tag, "_we_late"}, 32'(wcnt), 32'd0);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 13'h0010; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_rd"}, resp_rdata, exp_rd);
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      check({tag, "_hold_en"}, 32'(dm_en), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, "_vld_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_dm_en", 32'(dm_en), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_dm_addr", 32'(dm_addr), 32'd0);
    check("rst_dm_din", dm_din, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_req("sw",  1'b1, SZ_WORD, 1'b0, 13'h0FA8, 32'h12345678, 0, 4'b1111, 32'h12345678, 32'h0, 1'b0);
    check("sw_addr_1002", 32'(last_addr), 32'd1002);
    do_req("lw",  1'b0, SZ_WORD, 1'b0, 13'h0FA8, 32'h0, 0, 4'b0000, 32'h0, 32'h12345678, 1'b0);
    do_req("sb",  1'b1, SZ_BYTE, 1'b0, 13'h0FA9, 32'h000000AB, 0, 4'b0010, 32'hABABABAB, 32'h0, 1'b0);
    do_req("lb",  1'b0, SZ_BYTE, 1'b1, 13'h0FA9, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFFFAB, 1'b0);
    do_req("lbu", 1'b0, SZ_BYTE, 1'b0, 13'h0FA9, 32'h0, 0, 4'b0000, 32'h0, 32'h000000AB, 1'b0);
    do_req("sh",  1'b1, SZ_HALF, 1'b0, 13'h0FAA, 32'h00008001, 0, 4'b1100, 32'h80018001, 32'h0, 1'b0);
    do_req("lh",  1'b0, SZ_HALF, 1'b1, 13'h0FAA, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
    do_req("lhu", 1'b0, SZ_HALF, 1'b0, 13'h0FAA, 32'h0, 0, 4'b0000, 32'h0, 32'h00008001, 1'b0);
    do_req("lw2", 1'b0, SZ_WORD, 1'b0, 13'h0FA8, 32'h0, 0, 4'b0000, 32'h0, 32'h8001AB78, 1'b0);
    do_req("lb0", 1'b0, SZ_BYTE, 1'b1, 13'h0FA8, 32'h0, 0, 4'b0000, 32'h0, 32'h00000078, 1'b0);
    do_req("lh0", 1'b0, SZ_HALF, 1'b1, 13'h0FA8, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFAB78, 1'b0);

    // Response stall with a competing store waiting; that store must never reach the BRAM.
    do_req("hold", 1'b0, SZ_WORD, 1'b0, 13'h0FA8, 32'h0, 5, 4'b0000, 32'h0, 32'h8001AB78, 1'b0);
    do_req("lw_poison", 1'b0, SZ_WORD, 1'b0, 13'h0010, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b0);

    // Reset asserted while the store sits in ISSUE, before its BRAM edge.
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 13'h0020; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_issue_en", 32'(dm_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_dm_en", 32'(dm_en), 32'd0);
    check("rst_mid_dm_we", 32'(dm_we), 32'd0);
    check("rst_mid_dm_addr", 32'(dm_addr), 32'd0);
    check("rst_mid_dm_din", dm_din, 32'd0);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    en_cnt = 0;
    repeat (2) begin @(posedge clk); #1; if (dm_en) en_cnt++; end
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (dm_en) en_cnt++; end
    check("rst_mid_no_en", 32'(en_cnt), 32'd0);
    check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    do_req("lw_after_rst", 1'b0, SZ_WORD, 1'b0, 13'h0020, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b0);

`ifdef DM_ALIGN_CHECK_EN
    do_req("lw_mis", 1'b0, SZ_WORD, 1'b0, 13'h0FA9, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1);
`else
    do_req("lw_mis", 1'b0, SZ_WORD, 1'b0, 13'h0FA9, 32'h0, 0, 4'b0000, 32'h0, 32'h8001AB78, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
